// File: rtl/veri_bellek_hakemi_if.sv
// Requester-side bus for the data-memory arbiter: one instance per requester.
interface veri_bellek_hakemi_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/veri_bellek_hakemi.sv
// Two-requester round-robin arbiter in front of the single-port data memory.
// Requester 0 is the load/store path, requester 1 the loader/debug port.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; arbitration and fault check happen here
// ISSUE  | owner sees gnt; memory strobed unless the access faulted
// RESP   | owner sees rvalid/err/rdata; fault counter updated
module veri_bellek_hakemi #(
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    veri_bellek_hakemi_if.slave   m0,
    veri_bellek_hakemi_if.slave   m1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [IDX_W-1:0]      mem_idx,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic                cmd_we_q, cmd_we_d;
    logic                fault_q, fault_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [IDX_W-1:0]    mem_idx_q, mem_idx_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                pick1;
    logic                sel_we;
    logic [DATA_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_fault;

    // Winner selection and fault check on the full address of the winner.
    always_comb begin
        pick1     = m1.req && (!m0.req || !last_owner_q);
        sel_we    = pick1 ? m1.we    : m0.we;
        sel_addr  = pick1 ? m1.addr  : m0.addr;
        sel_wdata = pick1 ? m1.wdata : m0.wdata;
        sel_fault = (sel_addr[1:0] != 2'b00) ||
                    (sel_addr[DATA_W-1:2] >= (DATA_W-2)'(DEPTH));
    end

    // Next-state and next-output computation; outputs are one-hot per phase.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_we_d     = cmd_we_q;
        fault_d      = fault_q;
        err_count_d  = err_count_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_idx_d    = '0;
        mem_wdata_d  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (m0.req || m1.req) begin
                    state_d      = S_ISSUE;
                    owner_d      = pick1;
                    last_owner_d = pick1;
                    cmd_we_d     = sel_we;
                    fault_d      = sel_fault;
                    gnt0_d       = !pick1;
                    gnt1_d       = pick1;
                    if (!sel_fault) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_idx_d   = sel_addr[IDX_W+1:2];
                        mem_wdata_d = sel_wdata;
                    end
                end
            end
            S_ISSUE: begin
                state_d   = S_RESP;
                rvalid0_d = !owner_q;
                rvalid1_d = owner_q;
                err0_d    = !owner_q && fault_q;
                err1_d    = owner_q && fault_q;
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (fault_q && (err_count_q != 8'hFF)) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state and output flops; async reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cmd_we_q     <= 1'b0;
            fault_q      <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_idx_q    <= '0;
            mem_wdata_q  <= '0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cmd_we_q     <= cmd_we_d;
            fault_q      <= fault_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_idx_q    <= mem_idx_d;
            mem_wdata_q  <= mem_wdata_d;
            err_count_q  <= err_count_d;
        end
    end

    // Read data is the only non-registered output: memory data gated to the owner of a clean load.
    assign m0.rdata  = (rvalid0_q && !cmd_we_q && !fault_q) ? mem_rdata : '0;
    assign m1.rdata  = (rvalid1_q && !cmd_we_q && !fault_q) ? mem_rdata : '0;

    assign m0.gnt    = gnt0_q;
    assign m1.gnt    = gnt1_q;
    assign m0.rvalid = rvalid0_q;
    assign m1.rvalid = rvalid1_q;
    assign m0.err    = err0_q;
    assign m1.err    = err1_q;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_idx   = mem_idx_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign err_count = err_count_q;

endmodule

// File: tb/tb_veri_bellek_hakemi.sv
// Directed plus randomized bench for the data-memory arbiter.
module tb_veri_bellek_hakemi;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [6:0]  mem_idx;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [7:0]  err_count;

    veri_bellek_hakemi_if m0_if ();
    veri_bellek_hakemi_if m1_if ();

    veri_bellek_hakemi dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_idx   (mem_idx),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the arbiter: synchronous write, registered read, one-shot preload.
    logic [31:0] mem_arr  [128];
    logic [31:0] seed_arr [128];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem_arr[i] <= seed_arr[i];
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_idx] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_idx];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [128];
    int          exp_err;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_if.req = r; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
        end else begin
            m1_if.req = r; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= 128);
    endfunction

    // One isolated access from requester p, started at a negedge with the arbiter idle.
    task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        int          lat;
        bit          got;
        bit          flt;
        logic [31:0] exp_rd;
        flt = is_fault(a);
        drive(p, 1'b1, w, a, d);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = (p == 0) ? m0_if.gnt : m1_if.gnt;
        end
        chk("gnt_latency", lat, 1);
        if (!got) begin
            drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
            return;
        end
        chk("other_gnt", (p == 0) ? m1_if.gnt : m0_if.gnt, 0);
        chk("busy_issue", busy, 1);
        chk("mem_en", mem_en, !flt);
        if (!flt) begin
            chk("mem_we", mem_we, w);
            chk("mem_idx", mem_idx, a / 4);
            if (w) chk("mem_wdata", mem_wdata, d);
        end
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        exp_rd = (!w && !flt) ? ref_mem[a[8:2]] : 32'h0;
        chk("rvalid", (p == 0) ? m0_if.rvalid : m1_if.rvalid, 1);
        chk("err", (p == 0) ? m0_if.err : m1_if.err, flt);
        chk("rdata", (p == 0) ? m0_if.rdata : m1_if.rdata, exp_rd);
        chk("other_rvalid", (p == 0) ? m1_if.rvalid : m0_if.rvalid, 0);
        chk("mem_en_resp", mem_en, 0);
        if (w && !flt) ref_mem[a[8:2]] = d;
        if (flt) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
        @(negedge clk);
        chk("err_count", err_count, exp_err);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        w;
        int          p;
        int          r;
        bit          g0;
        bit          g1;
        checks   = 0;
        failures = 0;
        exp_err  = 0;
        rst      = 1'b1;
        preload  = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 128; i++) begin
            seed_arr[i] = $urandom();
            ref_mem[i]  = seed_arr[i];
        end
        seed_arr[4] = 32'hDEADBEEF;
        ref_mem[4]  = 32'hDEADBEEF;

        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        chk("rst_gnt0", m0_if.gnt, 0);
        chk("rst_gnt1", m1_if.gnt, 0);
        chk("rst_rvalid0", m0_if.rvalid, 0);
        chk("rst_rvalid1", m1_if.rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed: load of word 4, store/load of last legal word, two faults.
        access(0, 1'b0, 32'h10, 32'h0);
        access(1, 1'b1, 32'h1FC, 32'h12345678);
        access(0, 1'b0, 32'h1FC, 32'h0);
        access(1, 1'b1, 32'h6, 32'hAAAA5555);
        access(0, 1'b0, 32'h200, 32'h0);
        chk("err_count_two", err_count, 2);

        // Contention from reset: grants alternate starting with requester 0, every 3 cycles.
        rst = 1'b1;
        exp_err = 0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h1FC, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            g0 = (n % 3 == 1) && ((n / 3) % 2 == 0);
            g1 = (n % 3 == 1) && ((n / 3) % 2 == 1);
            chk("cont_gnt0", m0_if.gnt, g0);
            chk("cont_gnt1", m1_if.gnt, g1);
            if (n % 3 == 2) begin
                g0 = ((n / 3) % 2 == 0);
                chk("cont_rvalid0", m0_if.rvalid, g0);
                chk("cont_rvalid1", m1_if.rvalid, !g0);
                if (g0) chk("cont_rdata0", m0_if.rdata, ref_mem[4]);
                else    chk("cont_rdata1", m1_if.rdata, ref_mem[127]);
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset during ISSUE of a store: strobe drops at once, memory untouched.
        drive(0, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D);
        @(negedge clk);
        chk("abort_gnt_before", m0_if.gnt, 1);
        chk("abort_mem_en_before", mem_en, 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_mem_en", mem_en, 0);
        chk("abort_gnt", m0_if.gnt, 0);
        chk("abort_busy", busy, 0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_err = 0;
        chk("abort_word2", mem_arr[2], ref_mem[2]);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h1FC, 32'h0);
        @(negedge clk);
        chk("post_rst_gnt0", m0_if.gnt, 1);
        chk("post_rst_gnt1", m1_if.gnt, 0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("post_rst_rdata0", m0_if.rdata, ref_mem[4]);
        @(negedge clk);

        // Randomized mix of legal, misaligned and out-of-range accesses.
        access(1, 1'b0, 32'hFFFFFFFC, 32'h0);
        for (int k = 0; k < 40; k++) begin
            p = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 3);
            if (r <= 1)      a = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
            else if (r == 2) a = {23'h0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
            else             a = ($urandom() | 32'h200) & 32'hFFFFFFFC;
            access(p, w, a, $urandom());
        end

        // Saturation of the fault counter.
        for (int k = 0; k < 260; k++) begin
            access(k % 2, 1'(k % 3 == 0), (k % 2 == 0) ? 32'h201 : 32'h3, 32'h0);
        end
        chk("err_count_sat", err_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
